// File: rtl/msg_scroller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_scroller_pkg
// Purpose  : Shared types and constants for the message scroller: character
//            codes, FSM state encoding and the message ROM with its lengths.
// Revision : 1.0  initial release
// ============================================================================
package msg_scroller_pkg;

  typedef logic [3:0] char_t;

  // Character codes understood by the external character-to-segment decoders
  localparam char_t CH_H     = 4'h0;
  localparam char_t CH_I     = 4'h1;
  localparam char_t CH_T     = 4'h2;
  localparam char_t CH_B     = 4'h3;
  localparam char_t CH_U     = 4'h4;
  localparam char_t CH_S     = 4'h5;
  localparam char_t CH_W     = 4'h6;
  localparam char_t CH_N     = 4'h7;
  localparam char_t CH_L     = 4'h8;
  localparam char_t CH_O     = 4'h9;
  localparam char_t CH_E     = 4'hA;
  localparam char_t CH_P     = 4'hB;
  localparam char_t CH_BLANK = 4'hF;

  // Display geometry and ROM limits
  localparam int unsigned c_WINDOW  = 6;
  localparam int unsigned c_MAX_LEN = 8;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SCROLL = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Number of characters stored for each message (0 = unused slot)
  function automatic logic [3:0] msg_len(input logic [2:0] m);
    logic [3:0] len;
    case (m)
      3'd0:    len = 4'd3;
      3'd1:    len = 4'd4;
      3'd2:    len = 4'd3;
      3'd3:    len = 4'd4;
      3'd4:    len = 4'd4;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

  // Character at position p of message m; blank beyond the message length.
  // Each message is packed first-character-in-the-MSBs, up to 8 characters.
  function automatic char_t msg_char(input logic [2:0] m, input logic [3:0] p);
    logic [31:0] w;
    logic [31:0] w_sh;
    char_t       c;
    case (m)
      3'd0:    w = {CH_H, CH_I, CH_T, {5{CH_BLANK}}};
      3'd1:    w = {CH_B, CH_U, CH_S, CH_T, {4{CH_BLANK}}};
      3'd2:    w = {CH_W, CH_I, CH_N, {5{CH_BLANK}}};
      3'd3:    w = {CH_L, CH_O, CH_S, CH_E, {4{CH_BLANK}}};
      3'd4:    w = {CH_P, CH_U, CH_S, CH_H, {4{CH_BLANK}}};
      default: w = {8{CH_BLANK}};
    endcase
    w_sh = w << {p, 2'b00};
    if (p < msg_len(m)) c = w_sh[31:28];
    else                c = CH_BLANK;
    return c;
  endfunction

endpackage : msg_scroller_pkg
`default_nettype wire

// File: rtl/msg_scroller_if.sv
`default_nettype none
// ============================================================================
// Module   : msg_scroller_if
// Purpose  : Control and display bundle between a host and the scroller.
//            The master drives requests and reads the six character codes.
// Revision : 1.0  initial release
// ============================================================================
interface msg_scroller_if;
  import msg_scroller_pkg::*;

  logic       start;
  logic       stop;
  logic [2:0] msg_sel;
  char_t      char5;
  char_t      char4;
  char_t      char3;
  char_t      char2;
  char_t      char1;
  char_t      char0;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, msg_sel,
    input  char5, char4, char3, char2, char1, char0, busy, done
  );

  modport slave (
    input  start, stop, msg_sel,
    output char5, char4, char3, char2, char1, char0, busy, done
  );

endinterface : msg_scroller_if
`default_nettype wire

// File: rtl/msg_scroller_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running divider that pulses tick on the last cycle of every
//            DIV-cycle period while enabled; clear restarts the period.
// Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned DIV = 12500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned       CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  c_TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == c_TERM);
  assign tick   = en & w_term;

  // Count 0..DIV-1 while enabled, wrapping on the terminal count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_term) r_cnt <= '0;
      else        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : tick_gen
`default_nettype wire

// File: rtl/msg_scroller.sv
`default_nettype none
// ============================================================================
// Module   : msg_scroller
// Purpose  : Scrolls a ROM message right-to-left across six character
//            displays, one character per divider tick, optionally looping.
// Revision : 1.0  initial release
// ============================================================================
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12500000,
  parameter bit          LOOP     = 1'b0
) (
  input  logic           clk,
  input  logic           resetn,
  msg_scroller_if.slave  bus
);

  logic [1:0]       r_state;
  logic [2:0]       r_msg;
  logic [3:0]       r_len;
  logic [3:0]       r_pos;
  logic [5:0][3:0]  r_win;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_clear;
  logic             w_en;
  logic             w_last;
  char_t            w_next_char;

  // Divider restarts on LOAD (and on abort) so the first shift lands exactly
  // TICK_DIV cycles after SCROLL is entered.
  assign w_clear     = (r_state == LOAD) | bus.stop;
  assign w_en        = (r_state == SCROLL);
  // A pass is L message characters followed by six blanks to clear the window
  assign w_last      = (r_pos == (r_len + 4'd5));
  assign w_next_char = msg_char(r_msg, r_pos);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .clear  (w_clear),
    .en     (w_en),
    .tick   (w_tick)
  );

  // Control FSM plus the registered display window and status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_msg   <= 3'd0;
      r_len   <= 4'd0;
      r_pos   <= 4'd0;
      r_win   <= {6{CH_BLANK}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.stop) begin
      r_state <= IDLE;
      r_win   <= {6{CH_BLANK}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_win  <= {6{CH_BLANK}};
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        LOAD: begin
          r_msg   <= bus.msg_sel;
          r_len   <= msg_len(bus.msg_sel);
          r_pos   <= 4'd0;
          r_win   <= {6{CH_BLANK}};
          r_state <= SCROLL;
        end
        SCROLL: begin
          if (w_tick) begin
            r_win <= {r_win[4:0], w_next_char};
            if (w_last) begin
              if (LOOP) begin
                r_pos <= 4'd0;
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_pos <= r_pos + 4'd1;
            end
          end
        end
        DONE: begin
          r_win   <= {6{CH_BLANK}};
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_win   <= {6{CH_BLANK}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.char5 = r_win[5];
  assign bus.char4 = r_win[4];
  assign bus.char3 = r_win[3];
  assign bus.char2 = r_win[2];
  assign bus.char1 = r_win[1];
  assign bus.char0 = r_win[0];
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule : msg_scroller
`default_nettype wire
